mod_counter_ctrl: RTL
=====================

Name: mod_counter_ctrl

Overview:
Sequencing controller for the team's modulo-N counter datapath.
- Owns the count register and a programmable terminal value.
- Provides start/stop/pause/load control, a terminal-count pulse, and a wrap counter that ends a run after a programmed number of full periods.
- Sits between testbench or system control and the counter, replacing the ad hoc "AND-detect-then-clear" modulus logic with a clean synchronous FSM.

Parameters:
WIDTH, 4, width of count, load_val and mod_last
CW, 8, width of the cycles input and the internal wrap counter

Ports:
clk  input  1  rising-edge clock
clear  input  1  asynchronous active-low reset
start  input  1  level; begins or resumes a run (IDLE/DONE -> RUN)
stop  input  1  level; aborts the run, returns to IDLE with count cleared
pause  input  1  level; freezes count while high (RUN <-> HOLD)
load_en  input  1  loads load_val into count; honoured in IDLE only
load_val  input  WIDTH  preload value
mod_last  input  WIDTH  last count value of the period (modulus = mod_last+1)
cycles  input  CW  number of wraps before DONE; 0 = free-run
count  output  WIDTH  current count (registered)
tc  output  1  terminal-count pulse (registered)
busy  output  1  high in RUN or HOLD
done  output  1  high in DONE
state  output  2  IDLE=00, RUN=01, HOLD=10, DONE=11

Behaviour:
- Clock and reset are fixed: one clock `clk`; reset `clear` is asynchronous and active-low.
- Reset (clear=0, no clock needed): state=IDLE, count=0, wraps=0, tc=0; busy=0, done=0.
- All outputs come from registers; no combinational input-to-output path.
- Priority in every state: stop > pause > start > load_en > count.
- Terminal condition: count >= mod_last. Using >= covers mod_last lowered mid-run below count.
- IDLE:
  - load_en=1: count <= min(load_val, mod_last).
  - start=1: -> RUN. count keeps its value, wraps <= 0.
  - load_en and start in the same cycle: the load is applied and the state goes to RUN; the first increment happens on the next edge.
- RUN, per edge:
  - Not terminal: count <= count+1.
  - Terminal: count <= 0, wraps <= wraps+1, tc <= 1 for exactly one cycle (high during the cycle in which count shows 0).
  - If cycles != 0 and wraps+1 == cycles on a terminal edge: -> DONE on the same edge, count <= 0.
  - pause=1: -> HOLD with no increment on that edge.
  - stop=1: -> IDLE, count <= 0, wraps <= 0.
- HOLD:
  - count and wraps frozen; tc=0.
  - pause=0: -> RUN; the increment resumes on the following edge.
  - stop=1: -> IDLE, count cleared.
- DONE:
  - count=0, done=1.
  - start=1: -> RUN with wraps <= 0.
  - stop=1: -> IDLE.
  - load_en is ignored.
- mod_last=0: count stays 0 and tc is high on every RUN cycle after the first.
- cycles changed mid-run takes effect at the next terminal edge. If wraps has already passed cycles, the run continues until the CW-bit wrap counter wraps around.
- count is always kept <= mod_last, except in the single cycle after mod_last is lowered.

Optional Feature:
Macro DIR_EN.
- Defined:
  - Adds input port up_dn (1 bit).
  - up_dn=1 counts up exactly as above.
  - up_dn=0 counts down: the terminal condition is count==0, the wrap loads mod_last, and tc/wraps/DONE rules are unchanged.
  - A direction change takes effect on the next edge.
- Undefined: no up_dn port; up-count only.

Test Plan:
1. Free-run: mod_last=7, cycles=0, start held -> count 0,1,…,7,0,… ; tc high one cycle each time count returns to 0 (period 8); busy=1; done never asserted.
2. Finite run: mod_last=4, cycles=2, start -> exactly 10 increments, two tc pulses, then state=11, done=1, count=0. A start pulse restarts and the sequence repeats.
3. Pause/stop: pause at count=3 for 4 cycles -> count holds 3, state=10, then 4,5. stop at count=5 -> IDLE, count=0 next edge. pause+stop in the same cycle -> IDLE.
4. Load: IDLE, mod_last=7, load_val=6, load_en then start -> 6,7,0 with tc. load_val=9 with mod_last=7 -> count=7. load_en during RUN -> ignored.
5. Async reset mid-run: drive clear low between edges at count=5 -> count=0, state=00, tc=0 immediately, without a clock edge. After release, IDLE holds until start.
6. DIR_EN build: up_dn=0, mod_last=5, start from 0 -> 5,4,3,2,1,0,5; tc high in the cycle after each 0->5 wrap.

Source files
------------

// File: rtl/mod_counter_ctrl.sv
// Modulo-N counter sequencing controller: start/stop/pause/load, terminal-count pulse, wrap-limited runs.
// Optional macro DIR_EN adds the up_dn input for down-counting.
module mod_counter_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_last,
    input  logic [CW-1:0]    cycles,
`ifdef DIR_EN
    input  logic             up_dn,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic [CW-1:0]    r_wraps, w_wraps_nxt;
    logic             r_tc, w_tc_nxt;

    logic             w_up;
    logic             w_terminal;
    logic             w_last_wrap;
    logic [CW-1:0]    w_wraps_inc;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_wrap_val;
    logic [WIDTH-1:0] w_step;

`ifdef DIR_EN
    assign w_up = up_dn;
`else
    assign w_up = 1'b1;
`endif

    assign w_wraps_inc    = r_wraps + 1'b1;
    assign w_load_clamped = (load_val > mod_last) ? mod_last : load_val;
    // ">=" also catches mod_last lowered below the current count
    assign w_terminal     = w_up ? (r_count >= mod_last) : (r_count == '0);
    assign w_last_wrap    = (cycles != '0) && (w_wraps_inc == cycles);
    assign w_wrap_val     = w_up ? '0 : mod_last;
    // Down-count re-clamps to mod_last if it was lowered below count
    assign w_step         = w_up ? (r_count + 1'b1)
                                 : ((r_count > mod_last) ? mod_last : (r_count - 1'b1));

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state <= IDLE;
            r_count <= '0;
            r_wraps <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_wraps <= w_wraps_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_wraps_nxt = r_wraps;
        w_tc_nxt    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (stop) begin
                    w_count_nxt = '0;
                    w_wraps_nxt = '0;
                end else if (!pause) begin
                    if (load_en) w_count_nxt = w_load_clamped;
                    if (start) begin
                        w_state_nxt = RUN;
                        w_wraps_nxt = '0;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                    w_wraps_nxt = '0;
                end else if (pause) begin
                    w_state_nxt = HOLD;
                end else if (w_terminal) begin
                    w_wraps_nxt = w_wraps_inc;
                    w_tc_nxt    = 1'b1;
                    if (w_last_wrap) begin
                        w_state_nxt = DONE;
                        w_count_nxt = '0;
                    end else begin
                        w_count_nxt = w_wrap_val;
                    end
                end else begin
                    w_count_nxt = w_step;
                end
            end
            HOLD: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                    w_wraps_nxt = '0;
                end else if (!pause) begin
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                w_count_nxt = '0;
                if (stop) begin
                    w_state_nxt = IDLE;
                    w_wraps_nxt = '0;
                end else if (!pause && start) begin
                    w_state_nxt = RUN;
                    w_wraps_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
                w_wraps_nxt = '0;
            end
        endcase
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign state = r_state;
    assign busy  = (r_state == RUN) || (r_state == HOLD);
    assign done  = (r_state == DONE);

endmodule
